// File: rtl/jam_cost_eval.sv
// jam_cost_eval: scores the permutations streamed in by the permutation generator.
//   Each accepted (work, job) pair is driven to the external cost memory on W/J,
//   the returned Cost is summed per permutation, and the minimum total plus the
//   number of permutations reaching it are tracked. Valid rises once the final
//   permutation (the one closed by in_last) has been compared.
//
// Optional feature: define JAM_SEQ_CHECK_EN to build the expected-work sequence
//   checker behind seq_err. When undefined, seq_err is tied low.
//
// Ports:
//   CLK, RST          clock, synchronous active-high reset
//   in_valid          work/job pair present this cycle
//   work, job         worker/job index from the generator
//   in_last           marks the final pair of the final permutation
//   W, J              address to the cost memory (held between pairs)
//   Cost              cost of (W,J), sampled COST_LAT edges after W/J update
//   MinCost           minimum permutation total
//   MatchCount        permutations equal to MinCost, saturating
//   Valid             result ready, held until RST
//   seq_err           sticky work-sequence error
module jam_cost_eval #(
   parameter int unsigned N_WORK   = 8,
   parameter int unsigned COST_W   = 7,
   parameter int unsigned SUM_W    = 10,
   parameter int unsigned CNT_W    = 4,
   parameter int unsigned COST_LAT = 1
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              in_valid,
   input  logic [2:0]        work,
   input  logic [2:0]        job,
   input  logic              in_last,
   output logic [2:0]        W,
   output logic [2:0]        J,
   input  logic [COST_W-1:0] Cost,
   output logic [SUM_W-1:0]  MinCost,
   output logic [CNT_W-1:0]  MatchCount,
   output logic              Valid,
   output logic              seq_err
);

   localparam int unsigned IDX_W         = 3;
   localparam logic [IDX_W-1:0] LAST_WORK = IDX_W'(N_WORK - 1);

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_DRAIN = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   state_t r_state;
   state_t w_state_nxt;

   logic w_accept;
   logic w_sample;
   logic w_score;
   logic w_finish;

   // Tag pipeline: one slot per cycle of cost-memory latency
   logic [COST_LAT-1:0] r_tag_v;
   logic [COST_LAT-1:0] r_tag_eop;
   logic [COST_LAT-1:0] r_tag_last;

   logic [SUM_W-1:0] r_acc;
   logic [SUM_W-1:0] r_total;
   logic             r_tot_v;
   logic             r_tot_last;
   logic [SUM_W-1:0] w_sum;

   // State register
   always_ff @(posedge CLK) begin
      if (RST) r_state <= ST_RUN;
      else     r_state <= w_state_nxt;
   end

   // Next state and per-stage enables
   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_sample    = 1'b0;
      w_score     = 1'b0;
      w_finish    = 1'b0;
      case (r_state)
         ST_RUN: begin
            w_accept = in_valid;
            w_sample = r_tag_v[COST_LAT-1];
            w_score  = r_tot_v;
            if (in_valid && in_last) w_state_nxt = ST_DRAIN;
         end
         ST_DRAIN: begin
            w_sample = r_tag_v[COST_LAT-1];
            w_score  = r_tot_v;
            if (r_tot_v && r_tot_last) begin
               w_finish    = 1'b1;
               w_state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            w_state_nxt = ST_DONE;
         end
         default: w_state_nxt = ST_RUN;
      endcase
   end

   // Stage A: issue address and push the tag
   always_ff @(posedge CLK) begin
      if (RST) begin
         W          <= '0;
         J          <= '0;
         r_tag_v    <= '0;
         r_tag_eop  <= '0;
         r_tag_last <= '0;
      end else begin
         if (w_accept) begin
            W <= work;
            J <= job;
         end
         r_tag_v[0]    <= w_accept;
         r_tag_eop[0]  <= w_accept && (work == LAST_WORK);
         r_tag_last[0] <= w_accept && in_last;
         for (int i = 1; i < int'(COST_LAT); i++) begin
            r_tag_v[i]    <= r_tag_v[i-1];
            r_tag_eop[i]  <= r_tag_eop[i-1];
            r_tag_last[i] <= r_tag_last[i-1];
         end
      end
   end

   assign w_sum = r_acc + SUM_W'(Cost);

   // Stage B: accumulate; in_last also closes an incomplete permutation
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_acc      <= '0;
         r_total    <= '0;
         r_tot_v    <= 1'b0;
         r_tot_last <= 1'b0;
      end else begin
         r_tot_v <= 1'b0;
         if (w_sample) begin
            if (r_tag_eop[COST_LAT-1] || r_tag_last[COST_LAT-1]) begin
               r_total    <= w_sum;
               r_tot_v    <= 1'b1;
               r_tot_last <= r_tag_last[COST_LAT-1];
               r_acc      <= '0;
            end else begin
               r_acc <= w_sum;
            end
         end
      end
   end

   // Stage C: minimum tracking and completion
   always_ff @(posedge CLK) begin
      if (RST) begin
         MinCost    <= '1;
         MatchCount <= '0;
         Valid      <= 1'b0;
      end else begin
         if (w_score) begin
            if (r_total < MinCost) begin
               MinCost    <= r_total;
               MatchCount <= CNT_W'(1);
            end else if ((r_total == MinCost) && (MatchCount != '1)) begin
               MatchCount <= MatchCount + CNT_W'(1);
            end
         end
         if (w_finish) Valid <= 1'b1;
      end
   end

`ifdef JAM_SEQ_CHECK_EN
   logic [IDX_W-1:0] r_exp_work;
   logic             r_seq_err;

   // Expected-work counter; a mismatch latches seq_err until reset
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_exp_work <= '0;
         r_seq_err  <= 1'b0;
      end else if (w_accept) begin
         if (work != r_exp_work) r_seq_err <= 1'b1;
         r_exp_work <= (r_exp_work == LAST_WORK) ? '0 : r_exp_work + IDX_W'(1);
      end
   end

   assign seq_err = r_seq_err;
`else
   assign seq_err = 1'b0;
`endif

endmodule

// File: tb/tb_jam_cost_eval.sv
// Bench for jam_cost_eval: two instances (COST_LAT 1 and 3) share one input
// stream, each with its own cost-memory model built from a common table.
module tb_jam_cost_eval;

`ifdef JAM_SEQ_CHECK_EN
   localparam int SEQ_ON = 1;
`else
   localparam int SEQ_ON = 0;
`endif

   logic       CLK = 1'b0;
   logic       RST;
   logic       in_valid;
   logic       in_last;
   logic [2:0] work;
   logic [2:0] job;

   logic [2:0] w1, j1, w3, j3;
   logic [6:0] cost1, cost3;
   logic [9:0] min1, min3;
   logic [3:0] cnt1, cnt3;
   logic       v1, v3, se1, se3;

   logic [6:0] mem [8][8];
   logic [6:0] p3_0, p3_1;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 CLK = ~CLK;

   // Cost memory models: combinational for latency 1, two registers for latency 3
   assign cost1 = mem[w1][j1];
   always @(posedge CLK) begin
      p3_0 <= mem[w3][j3];
      p3_1 <= p3_0;
   end
   assign cost3 = p3_1;

   jam_cost_eval #(.COST_LAT(1)) u_dut1 (
      .CLK(CLK), .RST(RST), .in_valid(in_valid), .work(work), .job(job),
      .in_last(in_last), .W(w1), .J(j1), .Cost(cost1), .MinCost(min1),
      .MatchCount(cnt1), .Valid(v1), .seq_err(se1));

   jam_cost_eval #(.COST_LAT(3)) u_dut3 (
      .CLK(CLK), .RST(RST), .in_valid(in_valid), .work(work), .job(job),
      .in_last(in_last), .W(w3), .J(j3), .Cost(cost3), .MinCost(min3),
      .MatchCount(cnt3), .Valid(v3), .seq_err(se3));

   typedef struct {
      int n_perm;
      int val_a;
      int val_b;
      int exp_min;
      int exp_cnt;
   } vec_t;

   vec_t vecs [7];

   task automatic check(input string name, input logic [31:0] act, input int exp);
      n_tests++;
      if (act !== 32'(exp)) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic do_reset();
      RST = 1'b1; in_valid = 1'b0; in_last = 1'b0;
      step();
      RST = 1'b0;
   endtask

   task automatic send(input int w, input int j, input bit last, input int gap);
      in_valid = 1'b1; work = 3'(w); job = 3'(j); in_last = last;
      step();
      in_valid = 1'b0; in_last = 1'b0;
      repeat (gap) step();
   endtask

   task automatic fill_all(input int v);
      for (int a = 0; a < 8; a++)
         for (int b = 0; b < 8; b++) mem[a][b] = 7'(v);
   endtask

   task automatic set_rot(input int rot, input int v);
      for (int a = 0; a < 8; a++) mem[a][(a + rot) % 8] = 7'(v);
   endtask

   task automatic check_res(input string tag, input int emin, input int ecnt, input int ev);
      check({tag, " min1"}, 32'(min1), emin);
      check({tag, " cnt1"}, 32'(cnt1), ecnt);
      check({tag, " valid1"}, 32'(v1), ev);
      check({tag, " min3"}, 32'(min3), emin);
      check({tag, " cnt3"}, 32'(cnt3), ecnt);
      check({tag, " valid3"}, 32'(v3), ev);
   endtask

   // Called right after the last pair's accepting edge. Counting that edge as
   // the first, Valid must rise on edge COST_LAT+2, i.e. COST_LAT+1 edges later.
   task automatic wait_valid(input string tag);
      int lat1, lat3;
      lat1 = -1; lat3 = -1;
      for (int e = 1; e <= 16; e++) begin
         step();
         if (v1 && lat1 < 0) lat1 = e;
         if (v3 && lat3 < 0) lat3 = e;
      end
      check({tag, " latency1"}, 32'(lat1), 2);
      check({tag, " latency3"}, 32'(lat3), 4);
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, " W1"}, 32'(w1), 0);
      check({tag, " J1"}, 32'(j1), 0);
      check({tag, " W3"}, 32'(w3), 0);
      check({tag, " J3"}, 32'(j3), 0);
      check({tag, " seq1"}, 32'(se1), 0);
      check({tag, " seq3"}, 32'(se3), 0);
      check_res(tag, 1023, 0, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not end, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      RST = 1'b0; in_valid = 1'b0; in_last = 1'b0; work = '0; job = '0;
      fill_all(0);

      vecs[0] = '{n_perm: 1,  val_a: 5,   val_b: 5,   exp_min: 40,   exp_cnt: 1};
      vecs[1] = '{n_perm: 3,  val_a: 10,  val_b: 4,   exp_min: 32,   exp_cnt: 2};
      vecs[2] = '{n_perm: 17, val_a: 5,   val_b: 5,   exp_min: 40,   exp_cnt: 15};
      vecs[3] = '{n_perm: 2,  val_a: 3,   val_b: 9,   exp_min: 24,   exp_cnt: 1};
      vecs[4] = '{n_perm: 5,  val_a: 100, val_b: 100, exp_min: 800,  exp_cnt: 5};
      vecs[5] = '{n_perm: 1,  val_a: 0,   val_b: 0,   exp_min: 0,    exp_cnt: 1};
      vecs[6] = '{n_perm: 4,  val_a: 127, val_b: 127, exp_min: 1016, exp_cnt: 4};

      // Reset state, then costs 1..8 on the diagonal
      do_reset();
      check_reset_state("reset");
      fill_all(0);
      for (int w = 0; w < 8; w++) mem[w][w] = 7'(w + 1);
      for (int w = 0; w < 8; w++) send(w, w, w == 7, 0);
      wait_valid("single");
      check_res("single", 36, 1, 1);
      // Inputs after Valid must not disturb the frozen result
      set_rot(1, 0);
      for (int w = 0; w < 8; w++) send(w, (w + 1) % 8, 1'b1, 0);
      repeat (4) step();
      check_res("after_done", 36, 1, 1);

      // Table-driven permutation streams
      for (int v = 0; v < 7; v++) begin
         do_reset();
         fill_all(0);
         for (int p = 0; p < vecs[v].n_perm && p < 8; p++)
            set_rot(p, (p == 0) ? vecs[v].val_a : vecs[v].val_b);
         for (int p = 0; p < vecs[v].n_perm; p++)
            for (int w = 0; w < 8; w++)
               send(w, (w + p) % 8, (p == vecs[v].n_perm - 1) && (w == 7), 0);
         wait_valid($sformatf("vec%0d", v));
         check_res($sformatf("vec%0d", v), vecs[v].exp_min, vecs[v].exp_cnt, 1);
      end

      // Totals 20,15,15: continuous, then with idle gaps
      for (int g = 0; g <= 3; g += 3) begin
         do_reset();
         fill_all(0);
         for (int w = 0; w < 8; w++) begin
            mem[w][w]           = 7'((w % 2 == 0) ? 2 : 3);
            mem[w][(w + 1) % 8] = 7'((w == 0) ? 1 : 2);
            mem[w][(w + 2) % 8] = 7'((w == 0) ? 1 : 2);
         end
         for (int p = 0; p < 3; p++) begin
            for (int w = 0; w < 8; w++)
               send(w, (w + p) % 8, (p == 2) && (w == 7),
                    (w == 7) ? 0 : int'($urandom_range(0, g)));
            if (p == 0) begin
               repeat (6) step();
               check_res($sformatf("p3 g%0d first", g), 20, 1, 0);
            end else if (p == 1) begin
               repeat (6) step();
               check_res($sformatf("p3 g%0d second", g), 15, 1, 0);
            end
         end
         wait_valid($sformatf("p3 g%0d", g));
         check_res($sformatf("p3 g%0d final", g), 15, 2, 1);
      end

      // Reset mid-permutation discards the partial sum
      do_reset();
      fill_all(50);
      for (int w = 0; w < 4; w++) send(w, w, 1'b0, 0);
      do_reset();
      fill_all(100);
      check_reset_state("midrst");
      for (int w = 0; w < 8; w++) send(w, w, w == 7, 0);
      wait_valid("midrst");
      check_res("midrst", 800, 1, 1);

      // Incomplete final permutation is scored as a total
      do_reset();
      fill_all(0);
      set_rot(0, 0);
      for (int w = 0; w < 8; w++) begin
         mem[w][w]           = 7'(w + 1);
         mem[w][(w + 1) % 8] = 7'(w + 1);
      end
      for (int w = 0; w < 8; w++) send(w, w, 1'b0, 0);
      for (int w = 0; w < 3; w++) send(w, (w + 1) % 8, w == 2, 0);
      wait_valid("partial");
      check_res("partial", 6, 1, 1);

      // Work sequence 0,1,3,...
      do_reset();
      fill_all(1);
      send(0, 0, 1'b0, 0);
      send(1, 0, 1'b0, 0);
      check("seq ok1", 32'(se1), 0);
      check("seq ok3", 32'(se3), 0);
      send(3, 0, 1'b0, 0);
      check("seq bad1", 32'(se1), SEQ_ON);
      check("seq bad3", 32'(se3), SEQ_ON);
      for (int w = 4; w < 8; w++) send(w, 0, w == 7, 0);
      wait_valid("seq");
      check("seq held1", 32'(se1), SEQ_ON);
      check("seq held3", 32'(se3), SEQ_ON);
      check_res("seq", 7, 1, 1);
      do_reset();
      check("seq rst1", 32'(se1), 0);
      check("seq rst3", 32'(se3), 0);

      // Randomised streams against a reference model
      for (int it = 0; it < 40; it++) begin
         int n_perm, trunc, gmax, ref_min, ref_cnt, sum, lastw, j;
         do_reset();
         for (int a = 0; a < 8; a++)
            for (int b = 0; b < 8; b++) mem[a][b] = 7'($urandom_range(0, 127));
         n_perm  = int'($urandom_range(1, 5));
         trunc   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 6)) : 7;
         gmax    = int'($urandom_range(0, 2));
         ref_min = 1023;
         ref_cnt = 0;
         for (int p = 0; p < n_perm; p++) begin
            sum   = 0;
            lastw = (p == n_perm - 1) ? trunc : 7;
            for (int w = 0; w <= lastw; w++) begin
               j = int'($urandom_range(0, 7));
               sum += int'(mem[w][j]);
               send(w, j, (p == n_perm - 1) && (w == lastw),
                    ((p == n_perm - 1) && (w == lastw)) ? 0 : int'($urandom_range(0, gmax)));
            end
            if (sum < ref_min) begin
               ref_min = sum;
               ref_cnt = 1;
            end else if (sum == ref_min && ref_cnt < 15) begin
               ref_cnt++;
            end
         end
         wait_valid($sformatf("rand%0d", it));
         check_res($sformatf("rand%0d", it), ref_min, ref_cnt, 1);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
